// File: rtl/regfile_dbg_access_if.sv
// Bundle of the debug initiator's control, register-file and stream signals.
// The master side is the debug block; the slave side is the core/host around it.
interface regfile_dbg_access_if;
   logic        dump_start;
   logic        load_start;
   logic        busy;
   logic        done;
   logic        core_halt;
   logic [4:0]  dbg_rs;
   logic [31:0] dbg_rdata;
   logic [4:0]  dbg_rd;
   logic [31:0] dbg_wdata;
   logic        dbg_we;
   // Streams: a word moves on a rising edge where valid and ready are both high;
   // valid and data stay stable until that edge.
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  fsm_state;

   modport master (
      input  dump_start, load_start, dbg_rdata, out_ready, in_data, in_valid,
      output busy, done, core_halt, dbg_rs, dbg_rd, dbg_wdata, dbg_we,
             out_data, out_valid, in_ready, fsm_state
   );

   modport slave (
      output dump_start, load_start, dbg_rdata, out_ready, in_data, in_valid,
      input  busy, done, core_halt, dbg_rs, dbg_rd, dbg_wdata, dbg_we,
             out_data, out_valid, in_ready, fsm_state
   );
endinterface

// File: rtl/regfile_dbg_access.sv
// Debug initiator: halts the core and bulk-dumps or bulk-loads registers
// FIRST_REG..LAST_REG of the 32x32 register file over valid/ready streams.
module regfile_dbg_access #(
   parameter int unsigned FIRST_REG = 1,
   parameter int unsigned LAST_REG  = 31
) (
   input  logic                  clk,
   input  logic                  rst,
   regfile_dbg_access_if.master  bus
);
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_HALT      = 3'd1;
   localparam logic [2:0] S_DUMP_RD   = 3'd2;
   localparam logic [2:0] S_DUMP_SEND = 3'd3;
   localparam logic [2:0] S_LOAD      = 3'd4;
   localparam logic [2:0] S_DONE      = 3'd5;

   localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
   localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

   logic [2:0]  state_q, state_d;
   logic        mode_load_q, mode_load_d;
   logic [4:0]  idx_q, idx_d;
   logic [31:0] out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;
   logic [4:0]  dbg_rd_q, dbg_rd_d;
   logic [31:0] dbg_wdata_q, dbg_wdata_d;
   logic        dbg_we_q, dbg_we_d;

   always_comb begin
      state_d     = state_q;
      mode_load_d = mode_load_q;
      idx_d       = idx_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      dbg_rd_d    = dbg_rd_q;
      dbg_wdata_d = dbg_wdata_q;
      dbg_we_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Dump has priority when both starts arrive together.
            if (bus.dump_start) begin
               state_d     = S_HALT;
               mode_load_d = 1'b0;
               idx_d       = FIRST_IDX;
            end else if (bus.load_start) begin
               state_d     = S_HALT;
               mode_load_d = 1'b1;
               idx_d       = FIRST_IDX;
            end
         end
         S_HALT: state_d = mode_load_q ? S_LOAD : S_DUMP_RD;
         S_DUMP_RD: begin
            out_data_d  = bus.dbg_rdata;
            out_valid_d = 1'b1;
            state_d     = S_DUMP_SEND;
         end
         S_DUMP_SEND: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = S_DUMP_RD;
               end
            end
         end
         S_LOAD: begin
            // The write pulse is registered, so the last one lands in DONE.
            if (bus.in_valid) begin
               dbg_rd_d    = idx_q;
               dbg_wdata_d = bus.in_data;
               dbg_we_d    = 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mode_load_q <= 1'b0;
         idx_q       <= 5'd0;
         out_data_q  <= 32'd0;
         out_valid_q <= 1'b0;
         dbg_rd_q    <= 5'd0;
         dbg_wdata_q <= 32'd0;
         dbg_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_load_q <= mode_load_d;
         idx_q       <= idx_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         dbg_rd_q    <= dbg_rd_d;
         dbg_wdata_q <= dbg_wdata_d;
         dbg_we_q    <= dbg_we_d;
      end
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.core_halt = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.in_ready  = (state_q == S_LOAD);
   assign bus.dbg_rs    = idx_q;
   assign bus.dbg_rd    = dbg_rd_q;
   assign bus.dbg_wdata = dbg_wdata_q;
   assign bus.dbg_we    = dbg_we_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_regfile_dbg_access.sv
// Bench for regfile_dbg_access: a register-file model around the block, a
// scoreboard for dumped words and register writes, and directed/random steps.
module tb_regfile_dbg_access;
   localparam int FIRST = 1;
   localparam int LAST  = 31;
   localparam int NREG  = LAST - FIRST + 1;

   logic clk;
   logic rst;
   regfile_dbg_access_if bus ();

   regfile_dbg_access #(.FIRST_REG(FIRST), .LAST_REG(LAST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Register file seen by the core; x0 writes are discarded here.
   logic [31:0] rf [32];
   logic        preload_req = 1'b0;
   assign bus.dbg_rdata = rf[bus.dbg_rs];
   always @(posedge clk) begin
      if (preload_req) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + 32'(i);
      end else if (bus.core_halt && bus.dbg_we && bus.dbg_rd != 5'd0) begin
         rf[bus.dbg_rd] <= bus.dbg_wdata;
      end
   end

   logic [31:0] ref_rf [32];
   logic [31:0] exp_q[$];
   logic [36:0] exp_wr_q[$];
   logic [31:0] ldw [NREG];

   int total = 0;
   int bad   = 0;
   int word_cnt, extra_words, wr_cnt, extra_wr, done_cnt;
   int first_valid_cyc, done_cyc, first_we_cyc, last_we_cyc, c0;
   bit load_phase = 1'b0;
   bit prev_stall = 1'b0;
   logic [31:0] prev_data = 32'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_data", bus.out_data, prev_data);
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (bus.out_valid && bus.out_ready) begin
            word_cnt++;
            if (exp_q.size() != 0) chk("dump_word", bus.out_data, exp_q.pop_front());
            else extra_words++;
         end
         if (bus.dbg_we) begin
            wr_cnt++;
            if (first_we_cyc < 0) first_we_cyc = cyc;
            last_we_cyc = cyc;
            chk("we_window", 32'(bus.in_ready | bus.done), 32'd1);
            if (exp_wr_q.size() != 0) begin
               logic [36:0] e;
               e = exp_wr_q.pop_front();
               chk("wr_rd", 32'(bus.dbg_rd), 32'(e[36:32]));
               chk("wr_data", bus.dbg_wdata, e[31:0]);
            end else begin
               extra_wr++;
            end
         end
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            if (load_phase) chk("done_after_last_write", 32'(wr_cnt), 32'(NREG));
         end
      end
   end

   task automatic clear_stats();
      word_cnt = 0; extra_words = 0; wr_cnt = 0; extra_wr = 0;
      first_valid_cyc = -1; done_cyc = -1; first_we_cyc = -1; last_we_cyc = -1;
   endtask

   task automatic check_all_zero(input string pfx);
      chk({pfx, "_busy"},      32'(bus.busy), 32'd0);
      chk({pfx, "_done"},      32'(bus.done), 32'd0);
      chk({pfx, "_core_halt"}, 32'(bus.core_halt), 32'd0);
      chk({pfx, "_dbg_rs"},    32'(bus.dbg_rs), 32'd0);
      chk({pfx, "_dbg_rd"},    32'(bus.dbg_rd), 32'd0);
      chk({pfx, "_dbg_wdata"}, bus.dbg_wdata, 32'd0);
      chk({pfx, "_dbg_we"},    32'(bus.dbg_we), 32'd0);
      chk({pfx, "_out_data"},  bus.out_data, 32'd0);
      chk({pfx, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({pfx, "_in_ready"},  32'(bus.in_ready), 32'd0);
   endtask

   task automatic preload();
      for (int i = 0; i < 32; i++) ref_rf[i] = 32'h100 + 32'(i);
      @(posedge clk); #1 preload_req = 1'b1;
      @(posedge clk); #1 preload_req = 1'b0;
   endtask

   task automatic expect_dump();
      exp_q.delete();
      for (int r = FIRST; r <= LAST; r++) exp_q.push_back(ref_rf[r]);
   endtask

   // Waits (bounded) for the done pulse, then checks the halt drops next cycle.
   task automatic wait_done(input int budget, input bit rand_ready);
      int n;
      n = 0;
      while (1) begin
         @(negedge clk);
         if (bus.done) break;
         n++;
         if (n >= budget) begin
            chk("done_timeout", 32'(bus.done), 32'd1);
            return;
         end
         if (rand_ready) begin
            @(posedge clk); #1 bus.out_ready = 1'($urandom_range(0, 1));
         end
      end
      @(negedge clk);
      chk("halt_low_after_done", 32'(bus.core_halt), 32'd0);
      bus.out_ready = 1'b1;
   endtask

   task automatic pulse_start(input bit dump, input bit load);
      @(posedge clk); #1;
      c0 = cyc;
      bus.dump_start = dump;
      bus.load_start = load;
      @(posedge clk); #1;
      bus.dump_start = 1'b0;
      bus.load_start = 1'b0;
   endtask

   task automatic dump_end_checks(input string pfx);
      chk({pfx, "_words"}, 32'(word_cnt), 32'(NREG));
      chk({pfx, "_missing"}, 32'(exp_q.size()), 32'd0);
      chk({pfx, "_extra"}, 32'(extra_words), 32'd0);
      chk({pfx, "_no_writes"}, 32'(wr_cnt), 32'd0);
   endtask

   task automatic run_load(input bit gaps);
      int n;
      int budget;
      bit xfer;
      clear_stats();
      exp_wr_q.delete();
      for (int i = 0; i < NREG; i++) begin
         exp_wr_q.push_back({5'(FIRST + i), ldw[i]});
         ref_rf[FIRST + i] = ldw[i];
      end
      load_phase = 1'b1;
      @(posedge clk); #1;
      c0 = cyc;
      bus.load_start = 1'b1;
      bus.in_data    = ldw[0];
      bus.in_valid   = 1'b1;
      n = 0;
      budget = 0;
      while (n < NREG && budget < 300) begin
         @(negedge clk);
         xfer = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         bus.load_start = 1'b0;
         budget++;
         if (xfer) n++;
         if (n < NREG) begin
            bus.in_data  = ldw[n];
            bus.in_valid = gaps ? ~bus.in_valid : 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
      end
      chk("load_all_accepted", 32'(n), 32'(NREG));
      if (done_cyc < 0) wait_done(50, 1'b0);
      else begin
         @(negedge clk);
         chk("halt_low_after_load", 32'(bus.core_halt), 32'd0);
      end
      load_phase = 1'b0;
      chk("load_writes", 32'(wr_cnt), 32'(NREG));
      chk("load_extra_writes", 32'(extra_wr), 32'd0);
      chk("load_wr_missing", 32'(exp_wr_q.size()), 32'd0);
      chk("load_last_we_in_done", 32'(last_we_cyc), 32'(done_cyc));
   endtask

   initial begin
      int n;
      int dc0;
      rst = 1'b1;
      bus.dump_start = 1'b0;
      bus.load_start = 1'b0;
      bus.out_ready  = 1'b1;
      bus.in_data    = 32'd0;
      bus.in_valid   = 1'b0;
      clear_stats();
      done_cnt = 0;
      repeat (3) @(posedge clk);
      #2 check_all_zero("reset");
      @(posedge clk); #1 rst = 1'b0;

      // Dump without backpressure, with cycle-exact latency checks.
      preload();
      expect_dump();
      clear_stats();
      @(posedge clk); #1;
      c0 = cyc;
      bus.dump_start = 1'b1;
      @(negedge clk);
      chk("halt_cycle0", 32'(bus.core_halt), 32'd0);
      @(posedge clk); #1 bus.dump_start = 1'b0;
      @(negedge clk);
      chk("halt_cycle1", 32'(bus.core_halt), 32'd1);
      chk("busy_cycle1", 32'(bus.busy), 32'd1);
      wait_done(200, 1'b0);
      chk("first_valid_latency", 32'(first_valid_cyc - c0), 32'd3);
      chk("done_latency", 32'(done_cyc - c0), 32'd64);
      dump_end_checks("dump1");

      // Backpressure held for 5 cycles on x3, then random ready.
      expect_dump();
      clear_stats();
      pulse_start(1'b1, 1'b0);
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         if (bus.core_halt && bus.dbg_rs == 5'd3 && !bus.out_valid) break;
         n++;
      end
      chk("x3_reached", 32'(bus.dbg_rs), 32'd3);
      @(posedge clk); #1 bus.out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_data", bus.out_data, 32'h103);
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      wait_done(400, 1'b1);
      dump_end_checks("dump_bp");

      // Continuous load, then dump back.
      for (int i = 0; i < NREG; i++) ldw[i] = 32'hA000_0000 + 32'(FIRST + i);
      run_load(1'b0);
      chk("load_first_we_latency", 32'(first_we_cyc - c0), 32'd3);
      chk("load_we_consecutive", 32'(last_we_cyc - first_we_cyc), 32'(NREG - 1));
      expect_dump();
      clear_stats();
      pulse_start(1'b1, 1'b0);
      wait_done(200, 1'b0);
      dump_end_checks("dump_after_load");

      // Load with in_valid gaps and random data, checked by a random-ready dump.
      for (int i = 0; i < NREG; i++) ldw[i] = $urandom;
      run_load(1'b1);
      expect_dump();
      clear_stats();
      pulse_start(1'b1, 1'b0);
      wait_done(400, 1'b1);
      dump_end_checks("dump_after_gap_load");

      // Both starts together: dump wins; a load_start while busy is ignored.
      expect_dump();
      clear_stats();
      exp_wr_q.delete();
      pulse_start(1'b1, 1'b1);
      @(posedge clk); #1 bus.load_start = 1'b1;
      @(posedge clk); #1 bus.load_start = 1'b0;
      wait_done(200, 1'b0);
      dump_end_checks("prio_dump");
      repeat (3) @(negedge clk);
      chk("prio_idle_after", 32'(bus.busy), 32'd0);
      chk("prio_no_writes_after", 32'(wr_cnt), 32'd0);

      // Reset mid-dump after 10 words, then a clean restart from x1.
      preload();
      expect_dump();
      clear_stats();
      pulse_start(1'b1, 1'b0);
      n = 0;
      while (word_cnt < 10 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("words_before_reset", 32'(word_cnt), 32'd10);
      dc0 = done_cnt;
      #2 rst = 1'b1;
      #1 check_all_zero("midreset");
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("no_done_after_reset", 32'(done_cnt), 32'(dc0));
      chk("idle_after_reset", 32'(bus.core_halt), 32'd0);
      expect_dump();
      chk("restart_expect_x1", exp_q[0], 32'h101);
      clear_stats();
      pulse_start(1'b1, 1'b0);
      wait_done(200, 1'b0);
      dump_end_checks("dump_restart");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/regfile_dbg_access.md
Name: regfile_dbg_access

Overview:
- Debug initiator for the 32x32 register file. It halts the core, takes over the register file ports, and performs one of two bulk operations.
- Dump: streams register contents out over a valid/ready interface.
- Load: accepts a valid/ready stream of words and writes them into consecutive registers.
- Sits beside the core datapath. When core_halt is high, the core's register-file address, data and write-enable muxes select the dbg_* signals.

Parameters:
- FIRST_REG, 1, first register index processed (x0 skipped by default).
- LAST_REG, 31, last register index processed; constraint FIRST_REG <= LAST_REG <= 31.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- dump_start  in  1  request a dump; sampled only in IDLE.
- load_start  in  1  request a load; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at completion.
- core_halt  out  1  core stalled; register file muxed to this block.
- dbg_rs  out  5  register file read address.
- dbg_rdata  in  32  register file read data (combinational read of dbg_rs).
- dbg_rd  out  5  register file write address.
- dbg_wdata  out  32  register file write data.
- dbg_we  out  1  register file write enable.
- out_data  out  32  dump word.
- out_valid  out  1  dump word valid.
- out_ready  in  1  dump sink ready.
- in_data  in  32  load word.
- in_valid  in  1  load word valid.
- in_ready  out  1  block accepts a load word.

Behaviour:
- Reset (async, immediate): state IDLE, idx=0. All outputs are 0: busy, done, core_halt, dbg_rs, dbg_rd, dbg_wdata, dbg_we, out_data, out_valid, in_ready.
- Reset mid-operation aborts without completing. No done pulse, no further writes. A register already written stays written.
- The handshake rule is standard: a transfer happens on a rising edge where valid and ready are both high.

FSM states: IDLE, HALT, DUMP_RD, DUMP_SEND, LOAD, DONE.
- IDLE:
  - dump_start high -> HALT, mode=DUMP.
  - else load_start high -> HALT, mode=LOAD.
  - On either start, idx <= FIRST_REG. Dump wins if both starts are high.
  - Start pulses in any state other than IDLE are ignored.
- HALT: exactly one cycle, lets the core stall settle. Next state is DUMP_RD or LOAD per mode.
- DUMP_RD: dbg_rs=idx. At the end of the cycle, out_data <= dbg_rdata and out_valid <= 1. -> DUMP_SEND.
- DUMP_SEND:
  - out_valid and out_data are held stable until out_ready is high.
  - On transfer: out_valid <= 0. If idx==LAST_REG -> DONE, else idx <= idx+1 -> DUMP_RD.
  - Throughput is one word per 2 cycles when there is no backpressure.
- LOAD:
  - in_ready=1 in this state only.
  - On transfer: dbg_rd <= idx, dbg_wdata <= in_data, dbg_we <= 1 for exactly the next cycle (registered pulse).
  - If idx==LAST_REG -> DONE, else idx++ and stay in LOAD. Back-to-back accepts are allowed, one per cycle.
- DONE: one cycle.
  - done=1; any final dbg_we pulse lands in this cycle.
  - -> IDLE; core_halt drops on the same edge.
- core_halt = (state != IDLE). It is registered with the state, so it is high from the cycle after start until DONE ends.
- busy is equal to core_halt.
- dbg_we is never high outside LOAD or DONE. Any write the core makes to x0 is discarded by the register file itself, and that is not this block's concern.
- idx is 5 bits wide and never wraps; termination is the idx==LAST_REG compare.
- Latency for dump_start in cycle 0:
  - HALT in cycle 1 (core_halt=1).
  - DUMP_RD in cycle 2.
  - First out_valid in cycle 3.
  - Full dump with no backpressure and default params: done in cycle 64, core_halt low in cycle 65.

Test Plan:
- Dump, no backpressure: preload xN=0x100+N, out_ready=1, pulse dump_start at cycle 0.
  -> core_halt=1 at cycle 1.
  -> 31 words 0x101..0x11F in order, first at cycle 3.
  -> done pulse at cycle 64; core_halt=0 at cycle 65.
- Dump with backpressure: drop out_ready for 5 cycles while word x3 is presented.
  -> out_valid stays 1 and out_data stays 0x103 throughout.
  -> no word is skipped or duplicated.
- Load then dump: load_start, then stream in_data=0xA000_0000+N with in_valid=1 continuously.
  -> 31 dbg_we pulses with dbg_rd=1..31 on consecutive cycles.
  -> a following dump returns 0xA000_0001..0xA000_001F.
- Load with gaps: toggle in_valid every other cycle.
  -> dbg_we pulses only after accepted words.
  -> no extra writes; done is asserted only after the 31st write.
- Priority and ignore: dump_start and load_start in the same cycle.
  -> dump performed.
  -> a load_start issued while busy has no effect.
- Reset mid-dump: assert rst after 10 words.
  -> all outputs are 0 immediately, core_halt=0, no done pulse.
  -> the next dump_start restarts from x1 (0x101).
